// File: rtl/reset_pulse_pkg.sv
// Shared state encoding and default timing constants for reset_pulse_gen.
package reset_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  localparam int DEF_PULSE_CYCLES    = 4;
  localparam int DEF_COOLDOWN_CYCLES = 8;
  localparam int DEF_WDT_CYCLES      = 1024;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_pulse_gen_pulse_timer.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module pulse_timer
  import reset_pulse_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (value_q != '0) begin
      value_d = value_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= RESET_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/reset_pulse_gen.sv
// Registered reset-pulse generator with enforced cooldown.
// Optional watchdog compiled in with macro RESET_PULSE_WATCHDOG_EN.
module reset_pulse_gen
  import reset_pulse_pkg::*;
#(
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int WDT_CYCLES      = DEF_WDT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic kick,
  output logic reset_pulse_out,
  output logic busy,
  output logic done,
  output logic wdt_fired
);

  localparam int CNT_W = $clog2(max_int(PULSE_CYCLES, COOLDOWN_CYCLES) + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  =
    CNT_W'((COOLDOWN_CYCLES > 0) ? (COOLDOWN_CYCLES - 1) : 0);

  state_e           state_q, state_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic [CNT_W-1:0] unused_cnt_value;
  logic             start_req;

  assign busy = (state_q != IDLE);

`ifdef RESET_PULSE_WATCHDOG_EN
  // Down-count of remaining idle cycles; its reset value equals "zero elapsed".
  localparam int WDT_W = $clog2(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES - 1);

  logic             wdt_zero;
  logic             wdt_expire;
  logic [WDT_W-1:0] unused_wdt_value;

  assign wdt_expire = wdt_zero && (state_q == IDLE);

  pulse_timer #(
    .WIDTH     (WDT_W),
    .RESET_VAL (WDT_LOAD)
  ) u_wdt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (busy || kick || wdt_expire),
    .load_val_i (WDT_LOAD),
    .value_o    (unused_wdt_value),
    .zero_o     (wdt_zero)
  );

  assign wdt_fired = wdt_expire && !kick;
  assign start_req = req || wdt_fired;
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
  logic unused_kick;

  assign unused_kick = kick;
  assign wdt_fired   = 1'b0;
  assign start_req   = req;
`endif

  pulse_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .value_o    (unused_cnt_value),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = PULSE_LOAD;
    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d      = ASSERT;
          cnt_load     = 1'b1;
          cnt_load_val = PULSE_LOAD;
        end
      end
      ASSERT: begin
        if (cnt_zero) begin
          if (COOLDOWN_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d      = COOLDOWN;
            cnt_load     = 1'b1;
            cnt_load_val = COOL_LOAD;
          end
        end
      end
      COOLDOWN: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulse and done are computed one cycle early so they leave straight from flops.
  always_comb begin
    pulse_d = (state_d == ASSERT);
    done_d  = (state_q != IDLE) && (state_d == IDLE);
  end

  assign reset_pulse_out = pulse_q;
  assign done            = done_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Self-checking bench for reset_pulse_gen: window-based reference model plus literal
// pins; watchdog scenarios are enabled when RESET_PULSE_WATCHDOG_EN is defined.
module tb_reset_pulse_gen;

  localparam int P  = 4;
  localparam int CA = 8;
  localparam int CB = 0;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0;
  logic kick = 1'b0;
  logic pulseA, busyA, doneA, wdtA;
  logic pulseB, busyB, doneB, wdtB;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int cool[2] = '{CA, CB};
  int st[2] = '{0, 0};
  bit alive[2] = '{1'b0, 1'b0};
  int wdtElapsed[2] = '{0, 0};
  bit modelValid = 1'b0;

  reset_pulse_gen #(.PULSE_CYCLES(P), .COOLDOWN_CYCLES(CA), .WDT_CYCLES(W)) dutA (
    .clk(clk), .reset(reset), .req(req), .kick(kick),
    .reset_pulse_out(pulseA), .busy(busyA), .done(doneA), .wdt_fired(wdtA)
  );

  reset_pulse_gen #(.PULSE_CYCLES(P), .COOLDOWN_CYCLES(CB), .WDT_CYCLES(W)) dutB (
    .clk(clk), .reset(reset), .req(req), .kick(kick),
    .reset_pulse_out(pulseB), .busy(busyB), .done(doneB), .wdt_fired(wdtB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic q, input logic k);
    @(posedge clk);
    #1;
    reset = r;
    req   = q;
    kick  = k;
  endtask

  function automatic bit inWin(input int n, input int lo, input int hi);
    return (n >= lo) && (n <= hi);
  endfunction

  // Reference model: an accepted request at cycle s owns the windows
  // pulse [s+1, s+P], busy [s+1, s+P+C], done at s+P+C+1.
  always @(negedge clk) begin
    bit expP, expB, expD, expE, expW;
    string tag;
    for (int d = 0; d < 2; d++) begin
      tag  = (d == 0) ? "A" : "B";
      expP = alive[d] && inWin(cyc, st[d] + 1, st[d] + P);
      expB = alive[d] && inWin(cyc, st[d] + 1, st[d] + P + cool[d]);
      expD = alive[d] && (cyc == st[d] + P + cool[d] + 1);
`ifdef RESET_PULSE_WATCHDOG_EN
      expE = !expB && (wdtElapsed[d] == W - 1);
      expW = expE && !kick;
`else
      expE = 1'b0;
      expW = 1'b0;
`endif
      if (modelValid) begin
        checkOutput($sformatf("pulse%s", tag), (d == 0) ? pulseA : pulseB, expP);
        checkOutput($sformatf("busy%s", tag),  (d == 0) ? busyA  : busyB,  expB);
        checkOutput($sformatf("done%s", tag),  (d == 0) ? doneA  : doneB,  expD);
        checkOutput($sformatf("wdt%s", tag),   (d == 0) ? wdtA   : wdtB,   expW);
      end
      if (reset) begin
        alive[d]      = 1'b0;
        wdtElapsed[d] = 0;
      end else begin
        if (!expB && (req || expW)) begin
          st[d]    = cyc;
          alive[d] = 1'b1;
        end
        if (expB || kick || expE) wdtElapsed[d] = 0;
        else wdtElapsed[d] = wdtElapsed[d] + 1;
      end
    end
    if (reset) modelValid = 1'b1;
    cyc = cyc + 1;
  end

  initial begin
    // Single request: pulse k=1..4, busy k=1..12, done k=13 (B: busy 1..4, done 5)
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(0, 0, 1);
      #2;
      checkOutput("litPulseA", pulseA, (k >= 1) && (k <= 4));
      checkOutput("litBusyA",  busyA,  k <= 12);
      checkOutput("litDoneA",  doneA,  k == 13);
      checkOutput("litPulseB", pulseB, (k >= 1) && (k <= 4));
      checkOutput("litDoneB",  doneB,  k == 5);
    end

    // Requests during busy are dropped; timing is unchanged
    applyStimulus(0, 1, 1);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(0, (k == 2) || (k == 10), 1);
      #2;
      checkOutput("dropPulseA", pulseA, (k >= 1) && (k <= 4));
      checkOutput("dropBusyA",  busyA,  k <= 12);
      checkOutput("dropDoneA",  doneA,  k == 13);
    end

    // Reset mid-pulse truncates with no done strobe
    applyStimulus(0, 1, 1);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(k == 3, 0, 1);
      #2;
      checkOutput("truncPulseA", pulseA, (k >= 1) && (k <= 3));
      checkOutput("truncBusyA",  busyA,  k <= 3);
      checkOutput("truncDoneA",  doneA,  1'b0);
    end

    // Held request with zero cooldown: 4 high, 1 low with done, repeating
    applyStimulus(1, 0, 1);
    applyStimulus(0, 1, 1);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 1, 1);
      #2;
      checkOutput("heldPulseB", pulseB, ((k - 1) % 5) < 4);
      checkOutput("heldDoneB",  doneB,  ((k - 1) % 5) == 4);
    end

`ifdef RESET_PULSE_WATCHDOG_EN
    // Unkicked watchdog fires at k=15 and pulses k=16..19
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    #2;
    checkOutput("wdtStartA", wdtA, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      applyStimulus(0, 0, 0);
      #2;
      checkOutput("wdtFireA",  wdtA,   k == 15);
      checkOutput("wdtPulseA", pulseA, (k >= 16) && (k <= 19));
    end

    // Kick every 10 cycles keeps it quiet
    applyStimulus(1, 0, 0);
    for (int k = 0; k <= 40; k++) begin
      applyStimulus(0, 0, (k % 10) == 0);
      #2;
      checkOutput("wdtKickedA", wdtA, 1'b0);
    end

    // Kick coincident with expiry wins
    applyStimulus(1, 0, 0);
    for (int k = 0; k <= 20; k++) begin
      applyStimulus(0, 0, k == 15);
      #2;
      checkOutput("wdtCoincA",      wdtA,   1'b0);
      checkOutput("wdtCoincPulseA", pulseA, 1'b0);
    end
`endif

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 25,
                    $urandom_range(0, 99) < 4);
    end
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1);

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
